hilo_mul_unit: RTL and testbench

Multi-cycle unsigned multiplier with the architectural HI/LO registers. It executes MULTU using the auxiliary decoder's hilo_we as its start strobe. It serves MFHI/MFLO reads selected by the decoder's rf_awd_src encoding. It raises a stall while a read would observe an unfinished product, so the upstream core holds the instruction.

---
 rtl/mips_pkg.sv | 14 +
 rtl/shift_add_mul_dp.sv | 46 ++++
 rtl/hilo_mul_unit.sv | 85 ++++++++
 tb/tb_hilo_mul_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode encodings and the HI/LO multiplier state enum.
package mips_pkg;

  localparam logic [1:0] RFAWDALU = 2'b00;
  localparam logic [1:0] RFAWDHI  = 2'b01;
  localparam logic [1:0] RFAWDLO  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } hilo_state_e;

endpackage

// File: rtl/shift_add_mul_dp.sv
// Radix-2 shift-add multiply datapath: accumulator, multiplicand and iteration counter.
module shift_add_mul_dp #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // acc[2*WIDTH] holds the carry out of the upper-half add
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] added;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    added     = acc[0] ? {sum, acc[WIDTH-1:0]} : acc;
    prod_next = added[2*WIDTH:1];
    last      = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= {{(WIDTH+1){1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
    end else if (step) begin
      acc   <= {1'b0, prod_next};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_mul_unit.sv
// MULTU engine with architectural HI/LO registers, MFHI/MFLO read port and read-after-multiply stall.
module hilo_mul_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  hilo_state_e        state_q, state_d;
  logic               load, step, last;
  logic [2*WIDTH-1:0] prod_next;

  shift_add_mul_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (a),
    .b        (b),
    .prod_next(prod_next),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start is only honoured outside RUN; a start during RUN is dropped
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // HI/LO commit only on the final iteration, never partially
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (step && last) begin
      {hi, lo} <= prod_next;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    case (rd_sel)
      RFAWDHI: rd_data = hi;
      RFAWDLO: rd_data = lo;
      default: rd_data = '0;
    endcase
    stall = busy && ((rd_sel == RFAWDHI) || (rd_sel == RFAWDLO));
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed bench: stimulus pushes expected {hi,lo} into a scoreboard; a monitor checks on each done pulse.
module tb_hilo_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data, hi, lo;
  logic        busy, done, stall;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  hilo_mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts busy cycles starting just after the launch edge, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {hi, lo}, 64'hx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hilo", {hi, lo}, e);
      end
    end
  end

  initial begin
    int n;
    logic saw_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; rd_sel = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_busy_done", {62'h0, busy, done}, 64'h0);
    rd_sel = 2'b01; #1;
    chk("rst_rd_hi", {31'h0, stall, rd_data}, 64'h0);
    rd_sel = 2'b10; #1;
    chk("rst_rd_lo", {31'h0, stall, rd_data}, 64'h0);
    rd_sel = 2'b00;

    // 3 * 5
    a = 32'd3; b = 32'd5; start = 1'b1;
    exp_q.push_back({32'h0, 32'h0000000F});
    tick(); start = 1'b0;
    count_busy(n);
    chk("busy_cycles_3x5", 64'(n), 64'd32);
    chk("done_after_3x5", {63'h0, done}, 64'h1);
    tick();
    chk("done_one_cycle", {63'h0, done}, 64'h0);

    // max * max, HI read held, mid-run start ignored
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    tick(); start = 1'b0; rd_sel = 2'b01;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("run_busy", {63'h0, busy}, 64'h1);
      chk("run_stall", {63'h0, stall}, 64'h1);
      chk("run_hilo_hold", {hi, lo}, {32'h0, 32'h0000000F});
      if (i == 10) begin a = 32'd7; b = 32'd7; start = 1'b1; end
      tick();
      start = 1'b0;
    end
    #1;
    chk("max_done", {63'h0, done}, 64'h1);
    chk("max_done_stall", {63'h0, stall}, 64'h0);
    chk("max_done_rd_hi", {32'h0, rd_data}, {32'h0, 32'hFFFFFFFE});

    // back-to-back start in DONE, LO read in same cycle
    rd_sel = 2'b10; a = 32'h10000; b = 32'h10000; start = 1'b1; #1;
    chk("done_rd_lo", {31'h0, stall, rd_data}, {31'h0, 1'b0, 32'h00000001});
    exp_q.push_back({32'h00000001, 32'h00000000});
    tick(); start = 1'b0; rd_sel = 2'b00;
    count_busy(n);
    chk("busy_cycles_b2b", 64'(n), 64'd32);
    tick();

    // read + start same cycle from IDLE returns pre-multiply value
    chk("idle_state", {62'h0, busy, done}, 64'h0);
    rd_sel = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; #1;
    chk("idle_rd_start", {31'h0, stall, rd_data}, {31'h0, 1'b0, 32'h00000001});
    tick(); start = 1'b0; rd_sel = 2'b11; #1;
    chk("unused_sel", {31'h0, stall, rd_data}, 64'h0);
    chk("abort_run_busy", {63'h0, busy}, 64'h1);
    rd_sel = 2'b00;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy_done", {62'h0, busy, done}, 64'h0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", {63'h0, saw_done}, 64'h0);
    chk("abort_hilo_stays", {hi, lo}, 64'h0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
